// File: rtl/lb_dataplane_sf_if.sv
// Avalon-ST style beat bundle used for both the RX and TX sides of lb_dataplane_sf.
// master drives the beat, slave drives ready.
interface lb_dataplane_sf_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = 2,
    parameter int ERR_WIDTH   = 6
);
    logic [DATA_WIDTH-1:0]  data;
    logic                   valid;
    logic                   startofpacket;
    logic                   endofpacket;
    logic [EMPTY_WIDTH-1:0] empty;
    logic [ERR_WIDTH-1:0]   error;
    logic                   ready;

    modport master (
        output data, valid, startofpacket, endofpacket, empty, error,
        input  ready
    );

    modport slave (
        input  data, valid, startofpacket, endofpacket, empty, error,
        output ready
    );
endinterface

// File: rtl/lb_dataplane_sf.sv
// Store-and-forward packet buffer between MAC RX and TX; drops bad/overlong packets.
// Define LB_DP_SF_STATS_EN to add packet counters and a buffer level output.
module lb_dataplane_sf #(
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = $clog2(DATA_WIDTH / 8),
    parameter int ADDR_WIDTH  = 9,
    parameter int ERR_WIDTH   = 6
) (
    input logic               clk,
    input logic               reset_n,
    lb_dataplane_sf_if.slave  rx,
    lb_dataplane_sf_if.master tx
`ifdef LB_DP_SF_STATS_EN
    ,
    output logic [31:0]         stat_fwd_pkts,
    output logic [31:0]         stat_drop_pkts,
    output logic [ADDR_WIDTH:0] stat_level
`endif
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam int EW = 1 + EMPTY_WIDTH + DATA_WIDTH;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] ONE = PW'(1);

    typedef enum logic [1:0] {IDLE, WRITE, DISCARD} state_t;

    state_t state, state_n;
    logic [PW-1:0] wr_ptr, wr_n, commit_ptr, commit_n, rd_ptr, wa;
    logic [EW-1:0] mem [0:2**ADDR_WIDTH-1];
    logic [EW-1:0] r_q;
    logic [ERR_WIDTH-1:0] rx_err;
    logic rx_rdy, beat, full, sop_full, bad, we, fwd_inc;
    logic [1:0] drop_inc;
    logic r_vld, rd_en, tx_load, sop_next;
    logic tx_vld, tx_sop, tx_eop;
    logic [EMPTY_WIDTH-1:0] tx_emp;
    logic [DATA_WIDTH-1:0] tx_dat;

    assign rx.ready = rx_rdy;
    assign rx_err   = rx.error;
    assign beat     = rx.valid & rx_rdy;
    assign bad      = (rx_err != '0);
    assign full     = (wr_ptr - rd_ptr) == DEPTH;
    // A new SOP rewinds to commit_ptr, so room is judged from there.
    assign sop_full = (commit_ptr - rd_ptr) == DEPTH;

    always_comb begin
        state_n  = state;
        wr_n     = wr_ptr;
        commit_n = commit_ptr;
        we       = 1'b0;
        wa       = wr_ptr;
        fwd_inc  = 1'b0;
        drop_inc = 2'd0;
        if (beat && rx.startofpacket) begin
            if (state == WRITE) drop_inc = drop_inc + 2'd1;
            wr_n = commit_ptr;
            if (sop_full) begin
                drop_inc = drop_inc + 2'd1;
                state_n  = rx.endofpacket ? IDLE : DISCARD;
            end else begin
                we      = 1'b1;
                wa      = commit_ptr;
                wr_n    = commit_ptr + ONE;
                state_n = WRITE;
                if (rx.endofpacket) begin
                    state_n = IDLE;
                    if (bad) begin
                        wr_n     = commit_ptr;
                        drop_inc = drop_inc + 2'd1;
                    end else begin
                        commit_n = commit_ptr + ONE;
                        fwd_inc  = 1'b1;
                    end
                end
            end
        end else if (beat) begin
            unique case (state)
                IDLE: ;
                WRITE: begin
                    if (full) begin
                        wr_n     = commit_ptr;
                        drop_inc = 2'd1;
                        state_n  = rx.endofpacket ? IDLE : DISCARD;
                    end else begin
                        we   = 1'b1;
                        wr_n = wr_ptr + ONE;
                        if (rx.endofpacket) begin
                            state_n = IDLE;
                            if (bad) begin
                                wr_n     = commit_ptr;
                                drop_inc = 2'd1;
                            end else begin
                                commit_n = wr_ptr + ONE;
                                fwd_inc  = 1'b1;
                            end
                        end
                    end
                end
                DISCARD: if (rx.endofpacket) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Two-deep read pipe: RAM output register, then the TX register.
    assign tx_load = r_vld & (~tx_vld | tx.ready);
    assign rd_en   = (rd_ptr != commit_ptr) & (~r_vld | tx_load);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa[ADDR_WIDTH-1:0]] <= {rx.endofpacket, rx.empty, rx.data};
        end
        if (rd_en) r_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            rx_rdy     <= 1'b0;
            r_vld      <= 1'b0;
            sop_next   <= 1'b1;
            tx_vld     <= 1'b0;
            tx_sop     <= 1'b0;
            tx_eop     <= 1'b0;
            tx_emp     <= '0;
            tx_dat     <= '0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_n;
            commit_ptr <= commit_n;
            rx_rdy     <= 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + ONE;
            if (rd_en) r_vld <= 1'b1;
            else if (tx_load) r_vld <= 1'b0;
            if (tx_load) begin
                tx_vld   <= 1'b1;
                tx_sop   <= sop_next;
                tx_eop   <= r_q[EW-1];
                tx_emp   <= r_q[EW-1] ? r_q[DATA_WIDTH +: EMPTY_WIDTH] : '0;
                tx_dat   <= r_q[DATA_WIDTH-1:0];
                sop_next <= r_q[EW-1];
            end else if (tx.ready) begin
                tx_vld <= 1'b0;
            end
        end
    end

    assign tx.valid         = tx_vld;
    assign tx.startofpacket = tx_sop;
    assign tx.endofpacket   = tx_eop;
    assign tx.empty         = tx_emp;
    assign tx.data          = tx_dat;
    assign tx.error         = '0;

`ifdef LB_DP_SF_STATS_EN
    assign stat_level = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_fwd_pkts  <= '0;
            stat_drop_pkts <= '0;
        end else begin
            if (fwd_inc) stat_fwd_pkts <= stat_fwd_pkts + 32'd1;
            stat_drop_pkts <= stat_drop_pkts + {30'd0, drop_inc};
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{fwd_inc, drop_inc};
`endif
endmodule

// File: tb/tb_lb_dataplane_sf.sv
// Directed bench for lb_dataplane_sf (ADDR_WIDTH=4, 16-word buffer).
// Stats checks compile in when LB_DP_SF_STATS_EN is defined.
module tb_lb_dataplane_sf;
    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
        logic [1:0]  m;
    } word_t;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;
    int   stab_err;
    bit   rnd_en;
    bit   hold;
    word_t prev;
    word_t cur;
    word_t got[$];
    word_t exp_q[$];

    lb_dataplane_sf_if #(.DATA_WIDTH(32), .EMPTY_WIDTH(2), .ERR_WIDTH(6)) rx ();
    lb_dataplane_sf_if #(.DATA_WIDTH(32), .EMPTY_WIDTH(2), .ERR_WIDTH(1)) tx ();

`ifdef LB_DP_SF_STATS_EN
    logic [31:0] stat_fwd_pkts;
    logic [31:0] stat_drop_pkts;
    logic [4:0]  stat_level;
`endif

    lb_dataplane_sf #(
        .DATA_WIDTH(32),
        .EMPTY_WIDTH(2),
        .ADDR_WIDTH(4),
        .ERR_WIDTH(6)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx(rx.slave),
        .tx(tx.master)
`ifdef LB_DP_SF_STATS_EN
        ,
        .stat_fwd_pkts(stat_fwd_pkts),
        .stat_drop_pkts(stat_drop_pkts),
        .stat_level(stat_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TX monitor: records accepted words and any change while stalled.
    always @(posedge clk) begin
        cur = {tx.data, tx.startofpacket, tx.endofpacket, tx.empty};
        if (!reset_n) begin
            hold = 1'b0;
        end else begin
            if (hold && cur !== prev) stab_err++;
            if (tx.valid && tx.ready) got.push_back(cur);
            hold = tx.valid && !tx.ready;
            prev = cur;
        end
    end

    task automatic beat(input logic [31:0] d, input logic s, input logic e,
                        input logic [1:0] m, input logic [5:0] err);
        rx.data          = d;
        rx.startofpacket = s;
        rx.endofpacket   = e;
        rx.empty         = m;
        rx.error         = err;
        rx.valid         = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_rx();
        rx.valid         = 1'b0;
        rx.startofpacket = 1'b0;
        rx.endofpacket   = 1'b0;
        rx.empty         = '0;
        rx.error         = '0;
    endtask

    task automatic send_pkt(input int n, input logic [31:0] base,
                            input logic [1:0] emp, input logic [5:0] err);
        for (int j = 0; j < n; j++) begin
            beat(base + 32'(j), j == 0, j == n - 1,
                 (j == n - 1) ? emp : 2'd0, (j == n - 1) ? err : 6'd0);
        end
        idle_rx();
    endtask

    task automatic wait_words(input int n, input int budget);
        int c;
        c = 0;
        while (got.size() < n && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (got.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got %0d words, want %0d", got.size(), n);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cycles(2);
        vectors++;
        if (tx.valid !== 1'b0 || tx.startofpacket !== 1'b0 ||
            tx.endofpacket !== 1'b0 || tx.data !== 32'd0 ||
            tx.empty !== 2'd0 || tx.error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tx: got v%b s%b e%b d%h m%0d err%b want all 0",
                     tx.valid, tx.startofpacket, tx.endofpacket,
                     tx.data, tx.empty, tx.error);
        end
        vectors++;
        if (rx.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rx_ready: got %b want 0", rx.ready);
        end
        reset_n = 1'b1;
        cycles(1);
        vectors++;
        if (rx.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rx_ready_after_reset: got %b want 1", rx.ready);
        end
`ifdef LB_DP_SF_STATS_EN
        vectors++;
        if (stat_fwd_pkts !== 0 || stat_drop_pkts !== 0 || stat_level !== 0) begin
            miscompares++;
            $display("FAIL reset_stats: got %0d %0d %0d want 0 0 0",
                     stat_fwd_pkts, stat_drop_pkts, stat_level);
        end
`endif
    endtask

    task automatic test_basic();
        word_t w0, w2;
        got.delete();
        tx.ready = 1'b1;
        send_pkt(3, 32'hA0A0_0000, 2'd2, 6'd0);
        vectors++;
        if (tx.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_e0: tx_valid %b want 0", tx.valid);
        end
        cycles(1);
        vectors++;
        if (tx.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_e1: tx_valid %b want 0", tx.valid);
        end
        cycles(1);
        vectors++;
        if (tx.valid !== 1'b1 || tx.data !== 32'hA0A0_0000 ||
            tx.startofpacket !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_e2: v%b d%h s%b want 1 a0a00000 1",
                     tx.valid, tx.data, tx.startofpacket);
        end
        wait_words(3, 20);
        w0 = {32'hA0A0_0000, 1'b1, 1'b0, 2'd0};
        w2 = {32'hA0A0_0002, 1'b0, 1'b1, 2'd2};
        vectors++;
        if (got.size() != 3 || got[0] !== w0 || got[2] !== w2) begin
            miscompares++;
            $display("FAIL basic_pkt: n=%0d first %h last %h want 3 %h %h",
                     got.size(), got[0], got[got.size()-1], w0, w2);
        end
    endtask

    task automatic test_error();
        word_t w0, w1;
        got.delete();
        send_pkt(4, 32'hBAD0_0000, 2'd0, 6'h01);
        send_pkt(2, 32'h600D_0000, 2'd1, 6'd0);
        wait_words(2, 20);
        cycles(6);
        w0 = {32'h600D_0000, 1'b1, 1'b0, 2'd0};
        w1 = {32'h600D_0001, 1'b0, 1'b1, 2'd1};
        vectors++;
        if (got.size() != 2 || got[0] !== w0 || got[1] !== w1) begin
            miscompares++;
            $display("FAIL error_drop: n=%0d w0 %h want 2 words %h %h",
                     got.size(), got[0], w0, w1);
        end
`ifdef LB_DP_SF_STATS_EN
        vectors++;
        if (stat_fwd_pkts !== 32'd2 || stat_drop_pkts !== 32'd1) begin
            miscompares++;
            $display("FAIL error_stats: fwd %0d drop %0d want 2 1",
                     stat_fwd_pkts, stat_drop_pkts);
        end
`endif
    endtask

    task automatic test_overflow();
        word_t w0, w2;
        got.delete();
        tx.ready = 1'b0;
        for (int j = 0; j < 20; j++) begin
            beat(32'hF000_0000 + 32'(j), j == 0, j == 19, 2'd0, 6'd0);
`ifdef LB_DP_SF_STATS_EN
            if (j == 15) begin
                vectors++;
                if (stat_level !== 5'd16) begin
                    miscompares++;
                    $display("FAIL level_full: got %0d want 16", stat_level);
                end
            end
`endif
        end
        idle_rx();
        cycles(4);
        vectors++;
        if (tx.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_tx: tx_valid %b want 0", tx.valid);
        end
`ifdef LB_DP_SF_STATS_EN
        vectors++;
        if (stat_level !== 5'd0 || stat_drop_pkts !== 32'd2) begin
            miscompares++;
            $display("FAIL overflow_stats: level %0d drop %0d want 0 2",
                     stat_level, stat_drop_pkts);
        end
`endif
        send_pkt(3, 32'hC0DE_0000, 2'd3, 6'd0);
        cycles(4);
        vectors++;
        if (tx.valid !== 1'b1 || tx.data !== 32'hC0DE_0000 ||
            tx.startofpacket !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_next_head: v%b d%h s%b want 1 c0de0000 1",
                     tx.valid, tx.data, tx.startofpacket);
        end
        tx.ready = 1'b1;
        wait_words(3, 20);
        w0 = {32'hC0DE_0000, 1'b1, 1'b0, 2'd0};
        w2 = {32'hC0DE_0002, 1'b0, 1'b1, 2'd3};
        vectors++;
        if (got.size() != 3 || got[0] !== w0 || got[2] !== w2) begin
            miscompares++;
            $display("FAIL overflow_next: n=%0d w0 %h want 3 %h %h",
                     got.size(), got[0], w0, w2);
        end
    endtask

    task automatic test_trunc();
        word_t w0, w1, w2;
        got.delete();
        beat(32'hAAAA_0000, 1'b1, 1'b0, 2'd0, 6'd0);
        beat(32'hAAAA_0001, 1'b0, 1'b0, 2'd0, 6'd0);
        send_pkt(3, 32'hBBBB_0000, 2'd1, 6'd0);
        wait_words(3, 20);
        cycles(6);
        w0 = {32'hBBBB_0000, 1'b1, 1'b0, 2'd0};
        w1 = {32'hBBBB_0001, 1'b0, 1'b0, 2'd0};
        w2 = {32'hBBBB_0002, 1'b0, 1'b1, 2'd1};
        vectors++;
        if (got.size() != 3 || got[0] !== w0 || got[1] !== w1 ||
            got[2] !== w2) begin
            miscompares++;
            $display("FAIL trunc_sop: n=%0d w0 %h want 3 %h %h %h",
                     got.size(), got[0], w0, w1, w2);
        end
`ifdef LB_DP_SF_STATS_EN
        vectors++;
        if (stat_fwd_pkts !== 32'd4 || stat_drop_pkts !== 32'd3) begin
            miscompares++;
            $display("FAIL trunc_stats: fwd %0d drop %0d want 4 3",
                     stat_fwd_pkts, stat_drop_pkts);
        end
`endif
    endtask

    task automatic test_random();
        int c;
        int n;
        got.delete();
        exp_q.delete();
        stab_err = 0;
        rnd_en = 1'b1;
        fork
            while (rnd_en) begin
                @(posedge clk);
                #1;
                tx.ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 50; i++) begin
            n = (i % 4) + 1;
            for (int j = 0; j < n; j++) begin
                exp_q.push_back({32'h5000_0000 + 32'(i << 8) + 32'(j),
                                 j == 0, j == n - 1,
                                 (j == n - 1) ? 2'(i % 4) : 2'd0});
            end
            send_pkt(n, 32'h5000_0000 + 32'(i << 8), 2'(i % 4), 6'd0);
            c = 0;
            while (got.size() + 8 < exp_q.size() && c < 200) begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        wait_words(exp_q.size(), 2000);
        rnd_en = 1'b0;
        cycles(2);
        tx.ready = 1'b1;
        cycles(4);
        vectors++;
        if (got.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL random_count: got %0d words want %0d",
                     got.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            vectors++;
            if (got[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL random_word[%0d]: got %h want %h",
                         k, got[k], exp_q[k]);
            end
        end
        vectors++;
        if (stab_err != 0) begin
            miscompares++;
            $display("FAIL tx_stable: %0d changes while stalled, want 0",
                     stab_err);
        end
    endtask

    task automatic test_reset_mid();
        word_t w0, w1;
        got.delete();
        tx.ready = 1'b1;
        send_pkt(4, 32'hDEAD_0000, 2'd0, 6'd0);
        wait_words(1, 20);
        vectors++;
        if (tx.valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_tx_active: tx_valid %b want 1", tx.valid);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (tx.valid !== 1'b0 || rx.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: tx_valid %b rx_ready %b want 0 0",
                     tx.valid, rx.ready);
        end
        cycles(2);
        reset_n = 1'b1;
        cycles(1);
        got.delete();
        send_pkt(2, 32'h1234_0000, 2'd2, 6'd0);
        wait_words(2, 20);
        cycles(8);
        w0 = {32'h1234_0000, 1'b1, 1'b0, 2'd0};
        w1 = {32'h1234_0001, 1'b0, 1'b1, 2'd2};
        vectors++;
        if (got.size() != 2 || got[0] !== w0 || got[1] !== w1) begin
            miscompares++;
            $display("FAIL after_reset: n=%0d w0 %h want 2 %h %h",
                     got.size(), got[0], w0, w1);
        end
`ifdef LB_DP_SF_STATS_EN
        vectors++;
        if (stat_fwd_pkts !== 32'd1 || stat_drop_pkts !== 32'd0) begin
            miscompares++;
            $display("FAIL after_reset_stats: fwd %0d drop %0d want 1 0",
                     stat_fwd_pkts, stat_drop_pkts);
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        stab_err    = 0;
        rnd_en      = 1'b0;
        hold        = 1'b0;
        reset_n     = 1'b0;
        rx.data     = '0;
        tx.ready    = 1'b1;
        idle_rx();
        test_reset();
        test_basic();
        test_error();
        test_overflow();
        test_trunc();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
